// File: rtl/systolic_mac_pe_if.sv
// Operand, result-chain and status bundle of one systolic MAC processing element.
// The master drives operands and chain inputs; the PE is the slave.
interface systolic_mac_pe_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  start;
   logic [DATA_WIDTH-1:0] bias_in;
   logic [DATA_WIDTH-1:0] a_in;
   logic                  a_valid;
   logic                  a_last;
   logic [DATA_WIDTH-1:0] b_in;
   logic                  b_valid;
   logic [DATA_WIDTH-1:0] a_out;
   logic                  a_valid_out;
   logic                  a_last_out;
   logic [DATA_WIDTH-1:0] b_out;
   logic                  b_valid_out;
   logic                  shift_en;
   logic [DATA_WIDTH-1:0] res_in;
   logic                  res_valid_in;
   logic [DATA_WIDTH-1:0] res_out;
   logic                  res_valid_out;
   logic                  done;
   logic                  sat;
   logic                  err;
   logic [1:0]            state;

   modport master (
      output start, bias_in, a_in, a_valid, a_last, b_in, b_valid, shift_en, res_in,
             res_valid_in,
      input  a_out, a_valid_out, a_last_out, b_out, b_valid_out, res_out, res_valid_out,
             done, sat, err, state
   );

   modport slave (
      input  start, bias_in, a_in, a_valid, a_last, b_in, b_valid, shift_en, res_in,
             res_valid_in,
      output a_out, a_valid_out, a_last_out, b_out, b_valid_out, res_out, res_valid_out,
             done, sat, err, state
   );
endinterface

// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC processing element: forwards operands, accumulates a biased dot product,
// then rounds and saturates the result into a daisy-chained result shift register.
module systolic_mac_pe #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH   = 48,
   parameter int unsigned FRAC_BITS   = 0,
   parameter bit          SIGNED      = 1'b1,
   parameter int unsigned MAC_LATENCY = 3
) (
   input logic              clk,
   input logic              rst,
   systolic_mac_pe_if.slave bus
);
   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned SW = ACC_WIDTH + 1;
   localparam int unsigned CW = $clog2(MAC_LATENCY + 1);

   typedef enum logic [1:0] {StIdle = 2'd0, StAccum = 2'd1, StDrain = 2'd2} state_e;

   state_e               state_q;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] pipe_q [MAC_LATENCY];
   logic [CW-1:0]        cnt_q;

   logic                  pair;
   logic                  accept;
   logic [PW-1:0]         a_ext;
   logic [PW-1:0]         b_ext;
   logic [PW-1:0]         prod;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  bias_ext;
   logic [SW-1:0]         acc_ext;
   logic [SW-1:0]         rounded;
   logic [SW-1:0]         shifted;
   logic                  fits;
   logic [DATA_WIDTH-1:0] res_rnd;

   assign bus.state = state_q;

   always_comb begin
      pair   = bus.a_valid && bus.b_valid;
      accept = pair && (state_q == StAccum);
      if (SIGNED) begin
         a_ext    = {{DATA_WIDTH{bus.a_in[DATA_WIDTH-1]}}, bus.a_in};
         b_ext    = {{DATA_WIDTH{bus.b_in[DATA_WIDTH-1]}}, bus.b_in};
         bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.bias_in[DATA_WIDTH-1]}}, bus.bias_in};
         acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
      end else begin
         a_ext    = {{DATA_WIDTH{1'b0}}, bus.a_in};
         b_ext    = {{DATA_WIDTH{1'b0}}, bus.b_in};
         bias_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, bus.bias_in};
         acc_ext  = {1'b0, acc_q};
      end
      // Low PW bits of the product of extended operands are exact for either signedness.
      prod = a_ext * b_ext;
      if (SIGNED) prod_ext = ACC_WIDTH'($signed(prod));
      else        prod_ext = ACC_WIDTH'(prod);

      // One extra bit keeps the half-LSB rounding constant from wrapping the accumulator.
      rounded = acc_ext + ((SW'(1) << FRAC_BITS) >> 1);
      if (SIGNED) begin
         shifted = $signed(rounded) >>> FRAC_BITS;
         fits    = (&shifted[SW-1:DATA_WIDTH-1]) || !(|shifted[SW-1:DATA_WIDTH-1]);
         if (fits)                 res_rnd = shifted[DATA_WIDTH-1:0];
         else if (shifted[SW-1])   res_rnd = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         else                      res_rnd = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         shifted = rounded >> FRAC_BITS;
         fits    = !(|shifted[SW-1:DATA_WIDTH]);
         res_rnd = fits ? shifted[DATA_WIDTH-1:0] : '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= StIdle;
         acc_q             <= '0;
         cnt_q             <= '0;
         for (int unsigned i = 0; i < MAC_LATENCY; i++) pipe_q[i] <= '0;
         bus.a_out         <= '0;
         bus.a_valid_out   <= 1'b0;
         bus.a_last_out    <= 1'b0;
         bus.b_out         <= '0;
         bus.b_valid_out   <= 1'b0;
         bus.res_out       <= '0;
         bus.res_valid_out <= 1'b0;
         bus.done          <= 1'b0;
         bus.sat           <= 1'b0;
         bus.err           <= 1'b0;
      end else begin
         bus.a_out       <= bus.a_in;
         bus.a_valid_out <= bus.a_valid;
         bus.a_last_out  <= bus.a_last;
         bus.b_out       <= bus.b_in;
         bus.b_valid_out <= bus.b_valid;
         bus.done        <= 1'b0;
         bus.sat         <= 1'b0;

         // Idle pipe slots carry zero, so the accumulator can add unconditionally.
         pipe_q[0] <= accept ? prod_ext : '0;
         for (int unsigned i = 1; i < MAC_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
         acc_q <= acc_q + pipe_q[MAC_LATENCY-1];

         if (bus.shift_en) begin
            bus.res_out       <= bus.res_in;
            bus.res_valid_out <= bus.res_valid_in;
         end

         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  acc_q   <= bias_ext;
                  bus.err <= 1'b0;
                  state_q <= StAccum;
               end
            end
            StAccum: begin
               if (bus.start || (bus.a_valid ^ bus.b_valid)) bus.err <= 1'b1;
               if (accept && bus.a_last) begin
                  cnt_q   <= CW'(MAC_LATENCY);
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (bus.start || pair) bus.err <= 1'b1;
               if (cnt_q == '0) begin
                  bus.res_out       <= res_rnd;
                  bus.res_valid_out <= 1'b1;
                  bus.done          <= 1'b1;
                  bus.sat           <= !fits;
                  if (bus.shift_en) bus.err <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Drives three PE configurations (signed Q0, signed Q8, unsigned Q0) with shared stimulus and
// compares each against a plain-arithmetic dot-product model.
module tb_systolic_mac_pe;
   localparam int unsigned DW   = 16;
   localparam int          NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start, a_valid, a_last, b_valid, shift_en, res_valid_in;
   logic [DW-1:0] bias_in, a_in, b_in, res_in;

   logic [DW-1:0] o_res [NDUT];
   logic [DW-1:0] o_a   [NDUT];
   logic [DW-1:0] o_b   [NDUT];
   logic          o_done[NDUT];
   logic          o_sat [NDUT];
   logic          o_err [NDUT];
   logic          o_rv  [NDUT];
   logic          o_av  [NDUT];
   logic          o_bv  [NDUT];
   logic          o_al  [NDUT];
   logic [1:0]    o_st  [NDUT];
   logic [63:0]   o_all [NDUT];

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] pa[$];
   logic [DW-1:0] pb[$];
   logic [DW-1:0] bias_v;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      systolic_mac_pe_if #(.DATA_WIDTH(DW)) bus ();
      assign bus.start        = start;
      assign bus.bias_in      = bias_in;
      assign bus.a_in         = a_in;
      assign bus.a_valid      = a_valid;
      assign bus.a_last       = a_last;
      assign bus.b_in         = b_in;
      assign bus.b_valid      = b_valid;
      assign bus.shift_en     = shift_en;
      assign bus.res_in       = res_in;
      assign bus.res_valid_in = res_valid_in;
      assign o_res[g]  = bus.res_out;
      assign o_a[g]    = bus.a_out;
      assign o_b[g]    = bus.b_out;
      assign o_done[g] = bus.done;
      assign o_sat[g]  = bus.sat;
      assign o_err[g]  = bus.err;
      assign o_rv[g]   = bus.res_valid_out;
      assign o_av[g]   = bus.a_valid_out;
      assign o_bv[g]   = bus.b_valid_out;
      assign o_al[g]   = bus.a_last_out;
      assign o_st[g]   = bus.state;
      assign o_all[g]  = {7'd0, bus.a_out, bus.a_valid_out, bus.a_last_out, bus.b_out,
                          bus.b_valid_out, bus.res_out, bus.res_valid_out, bus.done, bus.sat,
                          bus.err, bus.state};

      systolic_mac_pe #(
         .DATA_WIDTH (DW),
         .ACC_WIDTH  (48),
         .FRAC_BITS  ((g == 1) ? 8 : 0),
         .SIGNED     (g != 2),
         .MAC_LATENCY(3)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns {sat, result} for configuration k from the queued pairs and bias.
   function automatic logic [DW:0] model(input int k);
      bit     sg = (k != 2);
      int     fr = (k == 1) ? 8 : 0;
      longint acc, lo, hi;
      if (sg) acc = longint'($signed(bias_v));
      else    acc = longint'(bias_v);
      for (int i = 0; i < pa.size(); i++) begin
         if (sg) acc += longint'($signed(pa[i])) * longint'($signed(pb[i]));
         else    acc += longint'(pa[i]) * longint'(pb[i]);
      end
      if (fr > 0) acc += longint'(1) << (fr - 1);
      acc = acc >>> fr;
      lo = sg ? -32768 : 0;
      hi = sg ? 32767 : 65535;
      if (acc > hi) return {1'b1, 16'(hi)};
      if (acc < lo) return {1'b1, 16'(lo)};
      return {1'b0, 16'(acc)};
   endfunction

   task automatic run_dot(input string tag, input bit inject_mm, input bit collide);
      int          cyc;
      logic [DW:0] exp;
      int          n = pa.size();
      // A valid pair while idle must be ignored.
      a_in = 16'($urandom); b_in = 16'($urandom); a_valid = 1; b_valid = 1; a_last = 1;
      step();
      a_valid = 0; b_valid = 0; a_last = 0;
      shift_en = collide; res_in = 16'h5A5A; res_valid_in = collide;
      start = 1; bias_in = bias_v;
      step();
      start = 0;
      check({tag, "_state_accum"}, 64'(o_st[0]), 64'd1);
      check({tag, "_err_cleared"}, 64'(o_err[0]), 64'd0);
      if (inject_mm) begin
         a_in = 16'h00AB; a_valid = 1; b_valid = 0;
         step();
         check({tag, "_fwd_a"}, 64'(o_a[0]), 64'h00AB);
         check({tag, "_fwd_av"}, 64'(o_av[0]), 64'd1);
         check({tag, "_fwd_bv"}, 64'(o_bv[0]), 64'd0);
         check({tag, "_mm_err"}, 64'(o_err[0]), 64'd1);
         a_valid = 0;
      end
      for (int i = 0; i < n; i++) begin
         a_valid = 0; b_valid = 0;
         repeat ($urandom_range(0, 2)) step();
         a_in = pa[i]; b_in = pb[i]; a_valid = 1; b_valid = 1; a_last = (i == n - 1);
         step();
      end
      a_valid = 0; b_valid = 0; a_last = 0;
      check({tag, "_fwd_b"}, 64'(o_b[0]), 64'(pb[n-1]));
      check({tag, "_fwd_last"}, 64'(o_al[0]), 64'd1);
      cyc = 0;
      do begin
         step();
         cyc++;
         if (cyc == 1) check({tag, "_state_drain"}, 64'(o_st[0]), 64'd2);
      end while (!o_done[0] && cyc < 10);
      check({tag, "_latency"}, 64'(cyc), 64'd4);
      for (int k = 0; k < NDUT; k++) begin
         exp = model(k);
         check($sformatf("%s_res%0d", tag, k), 64'(o_res[k]), 64'(exp[DW-1:0]));
         check($sformatf("%s_sat%0d", tag, k), 64'(o_sat[k]), 64'(exp[DW]));
         check($sformatf("%s_done%0d", tag, k), 64'(o_done[k]), 64'd1);
         check($sformatf("%s_rv%0d", tag, k), 64'(o_rv[k]), 64'd1);
         check($sformatf("%s_err%0d", tag, k), 64'(o_err[k]), 64'(inject_mm || collide));
         check($sformatf("%s_idle%0d", tag, k), 64'(o_st[k]), 64'd0);
      end
      shift_en = 0; res_valid_in = 0;
   endtask

   task automatic set_pairs(input int n);
      pa.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin
         pa.push_back($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20));
         pb.push_back($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20));
      end
   endtask

   task automatic one_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      pa.delete(); pb.delete();
      pa.push_back(a); pb.push_back(b);
   endtask

   initial begin
      start = 0; a_valid = 0; a_last = 0; b_valid = 0; shift_en = 0; res_valid_in = 0;
      bias_in = 0; a_in = 0; b_in = 0; res_in = 0;
      #1 rst = 1;
      #2;
      for (int k = 0; k < NDUT; k++) check($sformatf("reset_all%0d", k), o_all[k], 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      step();

      bias_v = 16'd5;
      pa = '{16'd2, -16'sd4, 16'd7};
      pb = '{16'd3, 16'd5, -16'sd1};
      run_dot("basic", 0, 0);
      check("basic_const", 64'(o_res[0]), 64'hFFF0);
      step();
      check("done_pulse", 64'(o_done[0]), 64'd0);

      shift_en = 1; res_in = 16'h1234; res_valid_in = 1;
      step();
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("chain_res%0d", k), 64'(o_res[k]), 64'h1234);
         check($sformatf("chain_rv%0d", k), 64'(o_rv[k]), 64'd1);
      end
      shift_en = 0; res_valid_in = 0;

      bias_v = 16'd0;
      one_pair(16'h0180, 16'h0100); run_dot("rnd1", 0, 0);
      check("rnd1_const", 64'(o_res[1]), 64'h0180);
      one_pair(16'h0001, 16'h0080); run_dot("rnd2", 0, 0);
      check("rnd2_const", 64'(o_res[1]), 64'h0001);
      one_pair(16'h0001, 16'h007F); run_dot("rnd3", 0, 0);
      check("rnd3_const", 64'(o_res[1]), 64'h0000);

      one_pair(16'h7FFF, 16'h7FFF); run_dot("sat1", 0, 0);
      check("sat1_const", 64'({o_sat[0], o_res[0]}), 64'h1_7FFF);
      one_pair(16'h8000, 16'h7FFF); run_dot("sat2", 0, 0);
      check("sat2_const", 64'({o_sat[0], o_res[0]}), 64'h1_8000);
      one_pair(16'hFFFF, 16'h0002); run_dot("sat3", 0, 0);
      check("sat3_const", 64'({o_sat[2], o_res[2]}), 64'h1_FFFF);

      bias_v = 16'($urandom); set_pairs(3); run_dot("mismatch", 1, 0);
      bias_v = 16'($urandom); set_pairs(2); run_dot("after_mm", 0, 0);
      bias_v = 16'($urandom); set_pairs(2); run_dot("collide", 0, 1);

      for (int r = 0; r < 8; r++) begin
         bias_v = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 64));
         set_pairs($urandom_range(1, 5));
         run_dot($sformatf("rand%0d", r), 0, 0);
      end

      bias_v = 16'($urandom);
      start = 1; bias_in = bias_v;
      step();
      start = 0; a_in = 16'($urandom); b_in = 16'($urandom); a_valid = 1; b_valid = 1;
      step();
      step();
      #2 rst = 1;
      #1;
      for (int k = 0; k < NDUT; k++) check($sformatf("async_rst%0d", k), o_all[k], 64'd0);
      #2 rst = 0;
      a_valid = 0; b_valid = 0;
      step();
      bias_v = 16'($urandom); set_pairs(4); run_dot("post_rst", 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
